// File: rtl/imm_pkg.sv
// imm_pkg: shared imm_sel encoding, instruction field layout and immediate range helper.
package imm_pkg;
  localparam logic [2:0] S_type = 3'b000;
  localparam logic [2:0] B_type = 3'b001;
  localparam logic [2:0] J_type = 3'b010;
  localparam logic [2:0] I_type = 3'b011;
  localparam logic [2:0] R_type = 3'b100;
  localparam logic [2:0] U_type = 3'b110;
  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_fields_t;
  // True when v[31:msb] are all equal, i.e. v fits a signed field whose sign bit is msb.
  function automatic logic upper_same(input logic [31:0] v, input int msb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << msb;
    return ((v & m) == m) || ((v & m) == 32'h0);
  endfunction
endpackage

// File: rtl/instr_enc_core.sv
// instr_enc_core: combinational RV32I word builder from fields, immediate and format select.
module instr_enc_core
  import imm_pkg::*;
(
  input  instr_fields_t i_fields,
  input  logic [31:0]   i_imm,
  input  logic [2:0]    i_imm_sel,
  output logic [31:0]   o_instr,
  output logic          o_err
);
  instr_fields_t f;
  assign f = i_fields;
  always_comb begin
    o_instr = 32'h0;
    o_err   = 1'b0;
    case (i_imm_sel)
      I_type: begin
        o_instr = {i_imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
        o_err   = !upper_same(i_imm, 11);
      end
      S_type: begin
        o_instr = {i_imm[11:5], f.rs2, f.rs1, f.funct3, i_imm[4:0], f.opcode};
        o_err   = !upper_same(i_imm, 11);
      end
      B_type: begin
        o_instr = {i_imm[12], i_imm[10:5], f.rs2, f.rs1, f.funct3, i_imm[4:1], i_imm[11], f.opcode};
        o_err   = i_imm[0] || !upper_same(i_imm, 12);
      end
      J_type: begin
        o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], f.rd, f.opcode};
        o_err   = i_imm[0] || !upper_same(i_imm, 20);
      end
      U_type: begin
        o_instr = {i_imm[31:12], f.rd, f.opcode};
        o_err   = |i_imm[11:0];
      end
      R_type: o_instr = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      default: o_err = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_packer.sv
// instr_packer: valid/ready instruction assembler with output FIFO and word/error counters.
module instr_packer
  import imm_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_imm_sel,
  input  logic [31:0]      i_imm,
  input  logic [6:0]       i_opcode,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [2:0]       i_funct3,
  input  logic [6:0]       i_funct7,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_instr,
  output logic             o_err,
  output logic [CNT_W-1:0] o_word_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } entry_t;
  entry_t mem_q [FIFO_DEPTH];
  entry_t mem_d [FIFO_DEPTH];
  entry_t last_q, last_d, head;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d, err_cnt_q, err_cnt_d;
  logic [31:0] enc_instr;
  logic enc_err, empty, full, push, pop;
  instr_fields_t fields;
  assign fields = '{funct7: i_funct7, rs2: i_rs2, rs1: i_rs1, funct3: i_funct3, rd: i_rd, opcode: i_opcode};
  instr_enc_core u_enc (
    .i_fields (fields),
    .i_imm    (i_imm),
    .i_imm_sel(i_imm_sel),
    .o_instr  (enc_instr),
    .o_err    (enc_err)
  );
  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push  = i_valid && !full;
  assign pop   = !empty && i_ready;
  assign head  = mem_q[rd_q[AW-1:0]];
  always_comb begin
    mem_d      = mem_q;
    mem_d[wr_q[AW-1:0]] = push ? entry_t'{enc_err, enc_instr} : mem_q[wr_q[AW-1:0]];
    wr_d       = push ? wr_q + 1'b1 : wr_q;
    rd_d       = pop ? rd_q + 1'b1 : rd_q;
    last_d     = pop ? head : last_q;
    word_cnt_d = word_cnt_q + CNT_W'(push);
    err_cnt_d  = err_cnt_q + CNT_W'(push && enc_err);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      last_q     <= '0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      last_q     <= last_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end
  // When drained, the output keeps showing the most recently popped word.
  assign o_ready    = !full;
  assign o_valid    = !empty;
  assign o_instr    = empty ? last_q.instr : head.instr;
  assign o_err      = empty ? last_q.err : head.err;
  assign o_word_cnt = word_cnt_q;
  assign o_err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_instr_packer.sv
// tb_instr_packer: directed vectors with hand-computed encodings, errors, backpressure and reset.
module tb_instr_packer;
  logic        i_clk = 0, i_rst_n = 0, i_valid = 0, i_ready = 0;
  logic [2:0]  i_imm_sel = 0, i_funct3 = 0;
  logic [31:0] i_imm = 0;
  logic [6:0]  i_opcode = 0, i_funct7 = 0;
  logic [4:0]  i_rd = 0, i_rs1 = 0, i_rs2 = 0;
  logic        o_ready, o_valid, o_err;
  logic [31:0] o_instr;
  logic [15:0] o_word_cnt, o_err_cnt;
  int checks = 0, errors = 0;

  instr_packer #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_imm_sel(i_imm_sel), .i_imm(i_imm), .i_opcode(i_opcode), .i_rd(i_rd),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_funct3(i_funct3), .i_funct7(i_funct7),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_err(o_err),
    .o_word_cnt(o_word_cnt), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] sel, input logic [31:0] imm, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7);
    i_imm_sel = sel; i_imm = imm; i_opcode = op; i_rd = rd;
    i_rs1 = rs1; i_rs2 = rs2; i_funct3 = f3; i_funct7 = f7;
  endtask

  // Called at a negedge with inputs set; returns #1 after the accepting edge.
  task automatic put();
    int n = 0;
    i_valid = 1;
    while (!o_ready && n < 20) begin @(negedge i_clk); n++; end
    if (n == 20) check("put_timeout", 32'(o_ready), 32'd1);
    @(posedge i_clk); #1 i_valid = 0;
  endtask

  task automatic xfer(input string tag, input logic [31:0] exp_instr, input logic exp_err);
    put();
    @(negedge i_clk);
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_instr"}, o_instr, exp_instr);
    check({tag, "_err"}, 32'(o_err), 32'(exp_err));
    i_ready = 1;
    @(posedge i_clk); #1 i_ready = 0;
    @(negedge i_clk);
    check({tag, "_drained"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_instr", o_instr, 32'h0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_wcnt", 32'(o_word_cnt), 32'd0);
    check("rst_ecnt", 32'(o_err_cnt), 32'd0);
    @(negedge i_clk); i_rst_n = 1;
    @(negedge i_clk);

    set_in(3'b011, 32'hFFFF_FFFF, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0); xfer("i_addi", 32'hFFF10093, 1'b0);
    set_in(3'b000, 32'd8, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0);       xfer("s_sw", 32'h00512423, 1'b0);
    set_in(3'b001, 32'hFFFF_FFFC, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0); xfer("b_beq", 32'hFE000EE3, 1'b0);
    set_in(3'b010, 32'h800, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);       xfer("j_jal", 32'h001000EF, 1'b0);
    set_in(3'b110, 32'h12345000, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0);  xfer("u_lui", 32'h123451B7, 1'b0);
    check("empty_hold", o_instr, 32'h123451B7);
    check("wcnt5", 32'(o_word_cnt), 32'd5);
    check("ecnt0", 32'(o_err_cnt), 32'd0);

    i_rst_n = 0; @(negedge i_clk); i_rst_n = 1; @(negedge i_clk);
    set_in(3'b011, 32'd2048, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0); xfer("i_big", 32'h80010093, 1'b1);
    set_in(3'b001, 32'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);    xfer("b_odd", 32'h00000163, 1'b1);
    set_in(3'b101, 32'd4, 7'b0010011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0);    xfer("sel_bad", 32'h0, 1'b1);
    check("err_wcnt", 32'(o_word_cnt), 32'd3);
    check("err_ecnt", 32'(o_err_cnt), 32'd3);

    set_in(3'b100, 32'hDEAD_BEEF, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20);
    i_valid = 1;
    @(negedge i_clk);
    check("bp_ready_after1", 32'(o_ready), 32'd1);
    set_in(3'b011, 32'd5, 7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0);
    @(negedge i_clk);
    check("bp_ready_after2", 32'(o_ready), 32'd0);
    check("bp_head_a", o_instr, 32'h403100B3);
    set_in(3'b110, 32'hABCDE000, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
    @(negedge i_clk);
    check("bp_held", 32'(o_word_cnt), 32'd5);
    i_ready = 1;
    @(posedge i_clk); #1 i_ready = 0;
    check("bp_no_passthru", 32'(o_word_cnt), 32'd5);
    @(negedge i_clk);
    check("bp_ready_reopen", 32'(o_ready), 32'd1);
    check("bp_head_b", o_instr, 32'h00500293);
    @(negedge i_clk);
    i_valid = 0;
    check("bp_c_accepted", 32'(o_word_cnt), 32'd6);
    check("bp_full_again", 32'(o_ready), 32'd0);
    check("bp_ecnt", 32'(o_err_cnt), 32'd3);
    i_ready = 1;
    @(posedge i_clk); #1 i_ready = 0;
    @(negedge i_clk);
    check("bp_head_c", o_instr, 32'hABCDE0B7);

    set_in(3'b011, 32'd7, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0);
    put();
    @(negedge i_clk);
    check("pre_rst_full", 32'(o_ready), 32'd0);
    #2 i_rst_n = 0;
    #1;
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_wcnt", 32'(o_word_cnt), 32'd0);
    check("arst_ecnt", 32'(o_err_cnt), 32'd0);
    @(negedge i_clk); i_rst_n = 1;
    @(negedge i_clk);
    check("arst_ready", 32'(o_ready), 32'd1);
    check("arst_instr", o_instr, 32'h0);
    check("arst_still_empty", 32'(o_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_packer.md
Name: instr_packer

Overview:
- Inverse of the immediate generator: builds a 32-bit RV32I instruction word from an opcode, register fields, and a 32-bit sign-extended immediate.
- Uses the same imm_sel encoding as the decoder path.
- Used by the debug/boot loader path to assemble instructions before they are written to instruction memory.
- Valid/ready input, small output FIFO, and per-word flag for an immediate that cannot be encoded.

Parameters:
- FIFO_DEPTH, 2, output buffer entries; power of 2, ≥2.
- CNT_W, 16, width of the accepted-word and error counters.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input request valid
- o_ready  out  1  packer can accept this cycle
- i_imm_sel  in  3  format: S=000 B=001 J=010 I=011 U=110 R=100; 101/111 illegal
- i_imm  in  32  immediate, already sign-extended or shifted as the decoder would output it
- i_opcode  in  7  instr[6:0]
- i_rd  in  5  destination register
- i_rs1  in  5  source register 1
- i_rs2  in  5  source register 2
- i_funct3  in  3  funct3 field
- i_funct7  in  7  funct7 field, used by R only
- o_valid  out  1  output word valid
- i_ready  in  1  consumer accepts output
- o_instr  out  32  packed instruction
- o_err  out  1  error flag for the word on o_instr
- o_word_cnt  out  CNT_W  words accepted since reset, wraps
- o_err_cnt  out  CNT_W  flagged words since reset, wraps

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FIFO emptied; o_valid=0; o_ready=1.
  - o_instr=0, o_err=0, both counters=0.
  - Mid-operation reset drops all buffered words.
- Accept: i_valid && o_ready. The word is encoded combinationally and written into the FIFO in the same edge.
- Latency: o_valid is high in the cycle after accept (1 cycle).
- Output handshake: a word is removed on o_valid && i_ready. o_instr and o_err stay stable while o_valid && !i_ready.
- o_ready = FIFO not full.
  - Full with a simultaneous pop: o_ready is still 0 that cycle. No pass-through.
- Push and pop in the same cycle (not full, not empty): occupancy unchanged, order preserved.
- Empty: o_valid=0, o_instr holds its last value.
- Packing, with opcode in [6:0] for every format:
  - I: {imm[11:0], rs1, funct3, rd, opcode}. err if imm[31:11] is not all-equal.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. err if imm[31:11] is not all-equal.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. err if imm[0]=1 or imm[31:12] is not all-equal.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}. err if imm[0]=1 or imm[31:20] is not all-equal.
  - U: {imm[31:12], rd, opcode}. err if imm[11:0] is nonzero.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}. Immediate ignored, err=0.
  - Illegal sel: instr=32'h0, err=1.
- An error word is still pushed, carrying the truncated packing and its err flag. It is never dropped.
- Counters:
  - o_word_cnt increments on every accept.
  - o_err_cnt increments on every accept whose err=1.
  - Both wrap modulo 2^CNT_W.

Decomposition:
- Package imm_pkg holds:
  - the imm_sel localparams (S_type, B_type, J_type, I_type, U_type, R_type);
  - a packed struct for the instruction fields (opcode, rd, rs1, rs2, funct3, funct7);
  - field bit-position constants.
- The decoder path should use this package as well.
- One sub-module: instr_enc_core, purely combinational. Inputs are fields + imm + sel; outputs are instr and err.
- instr_packer owns the FIFO, handshake and counters.

Test Plan:
- I, opcode 0010011, rd=1, rs1=2, f3=0, imm=32'hFFFFFFFF -> instr 32'hFFF10093, err=0, valid one cycle after accept.
- S (sw x5,8(x2)): opcode 0100011, rs1=2, rs2=5, f3=010, imm=8 -> 32'h00512423. B (beq x0,x0,-4): opcode 1100011, imm=32'hFFFFFFFC -> 32'hFE000EE3.
- J (jal x1,2048): opcode 1101111, imm=32'h800 -> 32'h001000EF. U (lui x3): opcode 0110111, imm=32'h12345000 -> 32'h123451B7.
- Errors:
  - I with imm=2048 -> err=1.
  - B with imm=3 -> err=1.
  - sel=101 -> instr=0, err=1.
  - After these 3 accepts, o_err_cnt=3 and o_word_cnt=3.
- Backpressure, i_ready=0 with 3 back-to-back valid requests:
  - first two accepted, o_ready=0 from the cycle after the 2nd accept, third held;
  - raise i_ready for 1 cycle -> one pop, third accepted next cycle;
  - output order matches input order.
- Reset asserted with 2 words buffered and i_ready=0 -> o_valid=0 immediately (async), counters 0, o_ready=1 after release.
